// File: rtl/tune_recorder.sv
// Maps keypad keys to a PWM half-period, live or from a recorded note/duration buffer.
// Live path and all outputs are registered (1-cycle latency); no backpressure, commands are single-cycle pulses.
module tune_recorder #(
  parameter int DEPTH    = 32,
  parameter int DUR_W    = 16,
  parameter int TICK_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic [15:0]              keys,
  input  logic                     rec,
  input  logic                     play,
  input  logic                     stop,
  output logic [9:0]               N,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_REC  = 2'b01;
  localparam logic [1:0] ST_PLAY = 2'b10;

  // Half-periods above 1023 (k1, k2) do not fit the 10-bit output and keep only their low bits.
  function automatic logic [9:0] key_map(input logic [15:0] k);
    logic [10:0] v;
    v = 11'd0;
    if      (k[0])  v = 11'd498;
    else if (k[10]) v = 11'd889;
    else if (k[11]) v = 11'd791;
    else if (k[12]) v = 11'd747;
    else if (k[13]) v = 11'd665;
    else if (k[14]) v = 11'd593;
    else if (k[15]) v = 11'd559;
    else if (k[1])  v = 11'd1185;
    else if (k[2])  v = 11'd1119;
    else if (k[3])  v = 11'd996;
    else if (k[7])  v = 11'd444;
    else if (k[8])  v = 11'd395;
    else if (k[9])  v = 11'd373;
    return v[9:0];
  endfunction

  logic [9:0]       mem_note [DEPTH];
  logic [DUR_W-1:0] mem_dur  [DEPTH];

  logic [PW-1:0]    presc;
  logic [9:0]       cur_note;
  logic [DUR_W-1:0] dur;
  logic [AW-1:0]    rd;
  logic [DUR_W-1:0] play_dur;
  logic [DUR_W-1:0] seg_ticks;

  logic [9:0]       live;
  logic             tick;
  logic [DUR_W-1:0] dur_eff;
  logic             seg_close;
  logic             do_write;
  logic             last_seg;
  logic             seg_done;
  logic [AW-1:0]    rd_nxt;

  // A segment closing on a tick edge still gets credit for that tick.
  always_comb begin
    live      = key_map(keys);
    tick      = (presc == PW'(TICK_DIV - 1));
    dur_eff   = (tick && (dur != {DUR_W{1'b1}})) ? dur + DUR_W'(1) : dur;
    seg_close = (state == ST_REC) && (stop || (live != cur_note));
    do_write  = seg_close && (dur_eff != '0);
    last_seg  = (CW'(rd) == count - CW'(1));
    seg_done  = (state == ST_PLAY) && tick && (seg_ticks == play_dur - DUR_W'(1));
    rd_nxt    = rd + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_note[count[AW-1:0]] <= cur_note;
      mem_dur[count[AW-1:0]]  <= dur_eff;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state     <= ST_IDLE;
      N         <= '0;
      count     <= '0;
      full      <= 1'b0;
      presc     <= '0;
      rd        <= '0;
      cur_note  <= '0;
      dur       <= '0;
      play_dur  <= '0;
      seg_ticks <= '0;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      case (state)
        ST_IDLE: begin
          N <= live;
          if (!stop && rec) begin
            count    <= '0;
            full     <= 1'b0;
            cur_note <= live;
            dur      <= '0;
            presc    <= '0;
            state    <= ST_REC;
          end else if (!stop && play && (count != '0)) begin
            rd        <= '0;
            N         <= mem_note[0];
            play_dur  <= mem_dur[0];
            seg_ticks <= '0;
            presc     <= '0;
            state     <= ST_PLAY;
          end
        end
        ST_REC: begin
          N <= live;
          if (seg_close) begin
            cur_note <= live;
            dur      <= '0;
            presc    <= '0;
            if (stop) state <= ST_IDLE;
            if (do_write) begin
              count <= count + CW'(1);
              if (count + CW'(1) == CW'(DEPTH)) begin
                full  <= 1'b1;
                state <= ST_IDLE;
              end
            end
          end else begin
            dur <= dur_eff;
          end
        end
        ST_PLAY: begin
          if (stop) begin
            N     <= '0;
            presc <= '0;
            state <= ST_IDLE;
          end else if (seg_done) begin
            presc     <= '0;
            seg_ticks <= '0;
            if (last_seg) begin
              N     <= '0;
              state <= ST_IDLE;
            end else begin
              rd       <= rd_nxt;
              N        <= mem_note[rd_nxt];
              play_dur <= mem_dur[rd_nxt];
            end
          end else if (tick) begin
            seg_ticks <= seg_ticks + DUR_W'(1);
          end
        end
        default: begin
          N     <= '0;
          presc <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tune_recorder.sv
// Directed bench for tune_recorder: key-map table plus record/playback/full/priority/reset sequences.
module tb_tune_recorder;
  logic        clk = 1'b0;
  logic        rst_l, rec, play, stop;
  logic [15:0] keys;
  logic [9:0]  N;
  logic [1:0]  state;
  logic [2:0]  count;
  logic        full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tune_recorder #(.DEPTH(4), .DUR_W(16), .TICK_DIV(4)) dut (
    .clk(clk), .rst_l(rst_l), .keys(keys), .rec(rec), .play(play), .stop(stop),
    .N(N), .state(state), .count(count), .full(full)
  );

  typedef struct {
    logic [15:0] k;
    int          exp_n;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse play, then expect up to four {note, cycles} segments back to back and a return to IDLE.
  task automatic play_expect(input string name,
                             input int n0, input int c0, input int n1, input int c1,
                             input int n2, input int c2, input int n3, input int c3);
    int nt [4];
    int ct [4];
    nt = '{n0, n1, n2, n3};
    ct = '{c0, c1, c2, c3};
    play = 1'b1;
    step();
    play = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < ct[s]; i++) begin
        chk({name, " N"}, int'(N), nt[s]);
        chk({name, " state"}, int'(state), 2);
        step();
      end
    end
    chk({name, " end state"}, int'(state), 0);
    chk({name, " end N"}, int'(N), 0);
  endtask

  initial begin
    vt[0]  = '{16'h0001, 498};
    vt[1]  = '{16'h0400, 889};
    vt[2]  = '{16'h0401, 498};
    vt[3]  = '{16'h0010, 0};
    vt[4]  = '{16'h0800, 791};
    vt[5]  = '{16'h1000, 747};
    vt[6]  = '{16'h2000, 665};
    vt[7]  = '{16'h4000, 593};
    vt[8]  = '{16'h8000, 559};
    vt[9]  = '{16'h0008, 996};
    vt[10] = '{16'h0080, 444};
    vt[11] = '{16'h0100, 395};
    vt[12] = '{16'h0200, 373};
    vt[13] = '{16'hFFFF, 498};
    vt[14] = '{16'h0070, 0};
    vt[15] = '{16'h0288, 996};
    vt[16] = '{16'hC000, 593};
    vt[17] = '{16'h0000, 0};

    rst_l = 1'b0; keys = '0; rec = 1'b0; play = 1'b0; stop = 1'b0;
    step();
    step();
    chk("reset N", int'(N), 0);
    chk("reset state", int'(state), 0);
    chk("reset count", int'(count), 0);
    chk("reset full", int'(full), 0);
    rst_l = 1'b1;
    step();

    // Live map with one-cycle latency
    keys = 16'h0001;
    #1;
    chk("live before edge", int'(N), 0);
    step();
    chk("live after edge", int'(N), 498);
    for (int i = 0; i < 18; i++) begin
      keys = vt[i].k;
      step();
      chk($sformatf("map[%0d]", i), int'(N), vt[i].exp_n);
    end

    // stop in IDLE is a no-op
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop idle state", int'(state), 0);

    // Record k13 x40, k0 x20, silence x8
    keys = 16'h2000; rec = 1'b1;
    step();
    rec = 1'b0;
    chk("rec state", int'(state), 1);
    chk("rec count cleared", int'(count), 0);
    repeat (39) step();
    keys = 16'h0001;
    step();
    chk("rec seg1 count", int'(count), 1);
    chk("rec live N", int'(N), 498);
    repeat (19) step();
    keys = 16'h0000;
    step();
    chk("rec seg2 count", int'(count), 2);
    repeat (7) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("rec stop count", int'(count), 3);
    chk("rec stop state", int'(state), 0);
    chk("rec stop full", int'(full), 0);
    play_expect("play1", 665, 40, 498, 20, 0, 8, 0, 0);
    play_expect("replay1", 665, 40, 498, 20, 0, 8, 0, 0);

    // Glitch filter: k13 x12, k7 x2, k13 x8
    keys = 16'h2000; rec = 1'b1;
    step();
    rec = 1'b0;
    repeat (11) step();
    keys = 16'h0080;
    step();
    chk("glitch pre count", int'(count), 1);
    step();
    keys = 16'h2000;
    step();
    chk("glitch discarded count", int'(count), 1);
    repeat (7) step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("glitch final count", int'(count), 2);
    play_expect("play_glitch", 665, 12, 665, 8, 0, 0, 0, 0);

    // Full: alternating k0/k10 segments of one tick each
    keys = 16'h0001; rec = 1'b1;
    step();
    rec = 1'b0;
    for (int s = 0; s < 5; s++) begin
      repeat (3) step();
      keys = (s % 2 == 0) ? 16'h0400 : 16'h0001;
      step();
      chk($sformatf("full count[%0d]", s), int'(count), (s < 4) ? s + 1 : 4);
      chk($sformatf("full state[%0d]", s), int'(state), (s < 3) ? 1 : 0);
      chk($sformatf("full flag[%0d]", s), int'(full), (s < 3) ? 0 : 1);
    end
    keys = 16'h0000;
    step();
    play_expect("play_full", 498, 4, 889, 4, 498, 4, 889, 4);

    // stop beats rec during PLAY; keys ignored while playing
    play = 1'b1;
    step();
    play = 1'b0;
    keys = 16'h0001;
    repeat (5) step();
    chk("play ignores keys", int'(N), 889);
    stop = 1'b1; rec = 1'b1;
    step();
    stop = 1'b0; rec = 1'b0;
    chk("stop+rec state", int'(state), 0);
    chk("stop+rec N", int'(N), 0);
    chk("stop+rec count", int'(count), 4);
    step();
    chk("idle live after stop", int'(N), 498);
    keys = 16'h0000;

    // Reset during playback
    play = 1'b1;
    step();
    play = 1'b0;
    repeat (5) step();
    chk("pre-reset state", int'(state), 2);
    rst_l = 1'b0;
    step();
    chk("mid-play reset N", int'(N), 0);
    chk("mid-play reset state", int'(state), 0);
    chk("mid-play reset count", int'(count), 0);
    chk("mid-play reset full", int'(full), 0);
    rst_l = 1'b1;
    step();

    // rec beats play; empty buffer cannot play
    rec = 1'b1; play = 1'b1;
    step();
    rec = 1'b0; play = 1'b0;
    chk("rec+play state", int'(state), 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("empty rec count", int'(count), 0);
    play = 1'b1;
    step();
    play = 1'b0;
    chk("play empty state", int'(state), 0);
    step();
    chk("play empty stays idle", int'(state), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
